// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand bypass beside decode: tracks in-flight destinations over DEPTH
// stages, forwards the youngest ready result and stalls decode on unready results or hold_i.
// Optional build macro HAZARD_PERF_EN adds saturating stall / forward performance counters.
module hazard_forward_unit #(
    parameter int unsigned  DATA_W     = 32,
    parameter int unsigned  REG_ADDR_W = 5,
    parameter int unsigned  DEPTH      = 3,
    localparam int unsigned SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      rd_en1_i,
    input  logic                      rd_en2_i,
    input  logic [REG_ADDR_W-1:0]     rnum1_i,
    input  logic [REG_ADDR_W-1:0]     rnum2_i,
    input  logic [DATA_W-1:0]         rf_data1_i,
    input  logic [DATA_W-1:0]         rf_data2_i,
    input  logic                      issue_valid_i,
    input  logic                      issue_we_i,
    input  logic                      issue_is_load_i,
    input  logic [REG_ADDR_W-1:0]     issue_wnum_i,
    input  logic [DEPTH-1:0]          res_valid_i,
    input  logic [DEPTH*DATA_W-1:0]   res_data_i,
    input  logic                      hold_i,
    output logic [DATA_W-1:0]         fwd_data1_o,
    output logic [DATA_W-1:0]         fwd_data2_o,
    output logic [SEL_W-1:0]          fwd_sel1_o,
    output logic [SEL_W-1:0]          fwd_sel2_o,
    output logic                      stall_o,
    output logic [31:0]               perf_stall_cnt_o,
    output logic [31:0]               perf_fwd_cnt_o
);

    localparam int unsigned CNT_W = 32;

    // In-flight slot tracking; index 0 is execute, DEPTH-1 is writeback.
    logic [DEPTH-1:0]                 slot_valid_q, slot_valid_d;
    logic [DEPTH-1:0]                 slot_we_q,    slot_we_d;
    logic [DEPTH-1:0]                 slot_load_q,  slot_load_d;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] slot_wnum_q,  slot_wnum_d;

    logic [DEPTH-1:0] match1_c, match2_c;
    logic [DEPTH-1:0] win1_c,   win2_c;
    logic             wait1_c,  wait2_c;
    logic             stall_c;

    // Select code of a one-hot winner: 0 = register file, k+1 = slot k.
    function automatic logic [SEL_W-1:0] win_sel(input logic [DEPTH-1:0] win);
        logic [SEL_W-1:0] sel;
        sel = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (win[k]) sel = SEL_W'(k + 1);
        end
        return sel;
    endfunction

    function automatic logic [DATA_W-1:0] win_data(input logic [DEPTH-1:0]        win,
                                                   input logic [DEPTH*DATA_W-1:0] res,
                                                   input logic [DATA_W-1:0]       rf);
        logic [DATA_W-1:0] data;
        data = rf;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (win[k]) data = res[k*DATA_W +: DATA_W];
        end
        return data;
    endfunction

    // Per-slot destination match for both sources; register 0 never matches.
    always_comb begin
        match1_c = '0;
        match2_c = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            match1_c[k] = rd_en1_i && (rnum1_i != '0) && slot_valid_q[k] && slot_we_q[k]
                          && (slot_wnum_q[k] == rnum1_i);
            match2_c[k] = rd_en2_i && (rnum2_i != '0) && slot_valid_q[k] && slot_we_q[k]
                          && (slot_wnum_q[k] == rnum2_i);
        end
    end

    // Lowest set bit isolates the youngest producer.
    always_comb begin
        win1_c  = match1_c & (~match1_c + DEPTH'(1));
        win2_c  = match2_c & (~match2_c + DEPTH'(1));
        wait1_c = |(win1_c & ~res_valid_i);
        wait2_c = |(win2_c & ~res_valid_i);
        stall_c = hold_i | wait1_c | wait2_c;
    end

    always_comb begin
        fwd_sel1_o  = win_sel(win1_c);
        fwd_sel2_o  = win_sel(win2_c);
        fwd_data1_o = win_data(win1_c, res_data_i, rf_data1_i);
        fwd_data2_o = win_data(win2_c, res_data_i, rf_data2_i);
        stall_o     = stall_c;
    end

    // Hold freezes everything; a dependency stall shifts but injects a bubble into execute.
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_we_d    = slot_we_q;
        slot_load_d  = slot_load_q;
        slot_wnum_d  = slot_wnum_q;
        if (!hold_i) begin
            for (int k = int'(DEPTH) - 1; k > 0; k--) begin
                slot_valid_d[k] = slot_valid_q[k-1];
                slot_we_d[k]    = slot_we_q[k-1];
                slot_load_d[k]  = slot_load_q[k-1];
                slot_wnum_d[k]  = slot_wnum_q[k-1];
            end
            if (stall_c) begin
                slot_valid_d[0] = 1'b0;
                slot_we_d[0]    = 1'b0;
                slot_load_d[0]  = 1'b0;
                slot_wnum_d[0]  = '0;
            end else begin
                slot_valid_d[0] = issue_valid_i;
                slot_we_d[0]    = issue_we_i;
                slot_load_d[0]  = issue_is_load_i;
                slot_wnum_d[0]  = issue_wnum_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_valid_q <= '0;
            slot_we_q    <= '0;
            slot_load_q  <= '0;
            slot_wnum_q  <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_we_q    <= slot_we_d;
            slot_load_q  <= slot_load_d;
            slot_wnum_q  <= slot_wnum_d;
        end
    end

    // Debug visibility: a decode operand waiting on an in-flight load.
    load_use_seen: cover property (@(posedge clk_i) disable iff (rst_i)
        |((win1_c | win2_c) & slot_load_q & ~res_valid_i));

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] fwd_cnt_q,   fwd_cnt_d;
    logic             fwd_event_c;

    // Saturating event counters.
    always_comb begin
        fwd_event_c = !stall_c && issue_valid_i && ((fwd_sel1_o != '0) || (fwd_sel2_o != '0));
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (fwd_event_c && (fwd_cnt_q != '1)) fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_fwd_cnt_o   = fwd_cnt_q;
`else
    assign perf_stall_cnt_o = '0;
    assign perf_fwd_cnt_o   = '0;
`endif

endmodule
